// File: rtl/rc4_sram_sequencer.sv
// Top-level scheduler for one RC4 pass: init -> KSA -> PRGA, owning the shared s_RAM write port.
// Optional per-phase watchdog enabled by defining RC4_SEQ_WATCHDOG_EN.
module rc4_sram_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       key_in,
    output logic              busy,
    output logic              done,
    output logic [1:0]        phase,
    output logic [23:0]       secret_key,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic              init_finish,
    input  logic              ksa_finish,
    input  logic              prga_finish,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    input  logic [ADDR_W-1:0] init_address,
    input  logic [ADDR_W-1:0] ksa_address,
    input  logic [ADDR_W-1:0] prga_address,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic [DATA_W-1:0] prga_data,
    output logic              sram_wren,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data,
    output logic              error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] W_INIT = 3'd2;
    localparam logic [2:0] S_KSA  = 3'd3;
    localparam logic [2:0] W_KSA  = 3'd4;
    localparam logic [2:0] S_PRGA = 3'd5;
    localparam logic [2:0] W_PRGA = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [23:0] key_q, key_d;

`ifdef RC4_SEQ_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    logic             waiting;
    logic             finish_sel;
    logic             timeout;

    always_comb begin
        waiting    = 1'b0;
        finish_sel = 1'b0;
        case (state_q)
            W_INIT:  begin waiting = 1'b1; finish_sel = init_finish; end
            W_KSA:   begin waiting = 1'b1; finish_sel = ksa_finish;  end
            W_PRGA:  begin waiting = 1'b1; finish_sel = prga_finish; end
            default: ;
        endcase
        // A finish on the limit cycle beats the timeout.
        timeout = waiting && !finish_sel && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d   = waiting ? cnt_q + CNT_W'(1) : '0;
        error_d = error_q;
        if (state_q == IDLE && start) error_d = 1'b0;
        if (timeout)                  error_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        case (state_q)
            IDLE:    if (start) begin
                         state_d = S_INIT;
                         key_d   = key_in;
                     end
            S_INIT:  state_d = W_INIT;
            W_INIT:  if (init_finish) state_d = S_KSA;
            S_KSA:   state_d = W_KSA;
            W_KSA:   if (ksa_finish) state_d = S_PRGA;
            S_PRGA:  state_d = W_PRGA;
            W_PRGA:  if (prga_finish) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef RC4_SEQ_WATCHDOG_EN
        if (timeout) state_d = IDLE;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // All control outputs decode registered state only, so they are glitch-free.
    always_comb begin
        case (state_q)
            S_INIT, W_INIT: phase = 2'd1;
            S_KSA,  W_KSA:  phase = 2'd2;
            S_PRGA, W_PRGA: phase = 2'd3;
            default:        phase = 2'd0;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign init_start = (state_q == S_INIT);
    assign ksa_start  = (state_q == S_KSA);
    assign prga_start = (state_q == S_PRGA);
    assign secret_key = key_q;

    always_comb begin
        sram_wren    = 1'b0;
        sram_address = '0;
        sram_data    = '0;
        case (phase)
            2'd1: begin sram_wren = init_wren; sram_address = init_address; sram_data = init_data; end
            2'd2: begin sram_wren = ksa_wren;  sram_address = ksa_address;  sram_data = ksa_data;  end
            2'd3: begin sram_wren = prga_wren; sram_address = prga_address; sram_data = prga_data; end
            default: ;
        endcase
    end

endmodule
